forward_bus_arbiter: RTL and testbench
======================================

// Module: forward_bus_arbiter
// PURPOSE
//   Collects results from NUM_LANES execution lanes, which are fed by reservation_station
//   dispatch, and drives them onto FORWARD_BUSSES shared result busses. These busses feed the
//   RS forward ports (forward_valids/indexes/values) and the ROB write ports.
//   Each lane has a small FIFO; a round-robin arbiter grants up to FORWARD_BUSSES lanes per cycle.
// PARAMETERS
//   XLEN              64  result value width
//   ROB_INDEX_WIDTH   8   ROB tag width
//   NUM_LANES         4   execution lanes feeding the arbiter (>= FORWARD_BUSSES)
//   FORWARD_BUSSES    2   result busses driven per cycle
//   LANE_FIFO_DEPTH   2   entries per lane FIFO (power of two, >= 2)
// PORTS
//   clock_i            in   1                          clock
//   reset_i            in   1                          async reset, active-low
//   flush_i            in   1                          pipeline flush (sync)
//   result_valids_i    in   NUM_LANES                  lane k result valid
//   result_readys_o    out  NUM_LANES                  lane k FIFO can accept
//   result_indexes_i   in   NUM_LANES*ROB_INDEX_WIDTH  lane k ROB tag, slice k
//   result_values_i    in   NUM_LANES*XLEN             lane k value, slice k
//   forward_valids_o   out  FORWARD_BUSSES             bus b carries a result this cycle
//   forward_indexes_o  out  FORWARD_BUSSES*ROB_INDEX_WIDTH  bus b ROB tag
//   forward_values_o   out  FORWARD_BUSSES*XLEN        bus b value
// BEHAVIOUR
//   - Reset (reset_i=0, async):
//     - All FIFOs empty; rr_ptr=0.
//     - forward_* = 0; result_readys_o = all 1.
//   - Lane handshake: push on posedge when valid&ready.
//     - ready_k = !full_k, taken from registered count only.
//     - A full FIFO refuses a push even if it is popped in the same cycle (no pass-through).
//   - Arbitration (combinational, each cycle):
//     - Scan lanes rr_ptr, rr_ptr+1, ... (mod NUM_LANES).
//     - Grant the first FORWARD_BUSSES non-empty lanes. The i-th grant goes to bus i, so busses
//       fill from bus 0 upward with no holes.
//     - Granted FIFO heads are popped at the posedge, and each one is loaded into the
//       registered bus b output.
//   - Output register:
//     - forward_valids_o is a one-cycle pulse per result.
//     - A bus with no grant drives valid=0, index=0, value=0.
//   - Latency: a result pushed at edge N appears on a bus after edge N+1 at the earliest.
//   - Pointer: rr_ptr <= (last granted lane + 1) mod NUM_LANES; it is unchanged when there
//     are no grants.
//   - Ordering: per lane, FIFO order is preserved. Across lanes there is no ordering
//     guarantee; the ROB handles order.
//   - Count: at most 1 push and 1 pop per lane per cycle, so the count changes by -1, 0 or +1.
//     Pointers wrap mod LANE_FIFO_DEPTH.
//   - flush_i=1 at posedge:
//     - All FIFOs are emptied and forward_valids_o <= 0.
//     - Pushes and pops that cycle are discarded; rr_ptr <= 0.
//     - Flush overrides every simultaneous event.
//   - Reset asserted mid-operation: identical to the reset state immediately; in-flight
//     results are lost.
//   - Duplicate ROB tags on two busses in one cycle are not checked; upstream guarantees
//     unique tags.
// STRUCTURE
//   - Shared package/header: no typedefs needed. Bus slice width macros
//     (XLEN, ROB_INDEX_WIDTH) come from the existing out_of_order core parameter header.
//   - One sub-module: forward_lane_fifo.
//     - Parameters: XLEN, ROB_INDEX_WIDTH, DEPTH.
//     - Ports: push/pop/full/empty/head, plus flush.
//     - Instantiated NUM_LANES times via generate.
//   - Top level holds: the rotating priority selector, which does FORWARD_BUSSES passes with
//     a mask of already-granted lanes; rr_ptr; and the output registers.
// TESTING
//   - T1 reset: reset_i=0 -> forward_valids_o=0, result_readys_o=4'b1111.
//     Release reset, idle 5 cycles -> still 0.
//   - T2 single result: lane2 pushes tag 7, value 64'h55 at edge N -> after edge N+1:
//     valid=2'b01, bus0 tag 7, value 64'h55. Next cycle valid=0.
//   - T3 contention: all 4 lanes push tags 1..4 in one cycle, rr_ptr=0 ->
//     - cycle 1: busses carry tags 1,2;
//     - cycle 2: busses carry tags 3,4;
//     - then rr_ptr=0.
//   - T4 fairness: lanes 0 and 3 push every cycle for 8 cycles with 2 busses -> every pushed
//     tag appears exactly once. Neither lane sees ready low more than 2 consecutive cycles.
//   - T5 backpressure: lane1 pushes 2 results while busses are granted to lanes 0, 2, 3
//     (keep them busy) -> lane1 ready=0 when count=2. A push attempt is refused.
//     The stored tags are later emitted in FIFO order.
//   - T6 flush: FIFOs hold 5 results; assert flush_i with a simultaneous push on lane0 ->
//     next cycle forward_valids_o=0, all readys=1, no stale tag is ever emitted.
//     rr_ptr=0 after the flush.

Source files
------------

// File: rtl/forward_bus_arbiter_pkg.sv
// Shared constants and helpers for the result forwarding arbiter.
// Default widths mirror the out-of-order core parameter header.
package forward_bus_arbiter_pkg;

  localparam int unsigned CoreXlen          = 64;
  localparam int unsigned CoreRobIndexWidth = 8;
  localparam int unsigned CoreNumLanes      = 4;
  localparam int unsigned CoreForwardBusses = 2;
  localparam int unsigned CoreLaneFifoDepth = 2;

  // Increment with wrap for moduli that need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned modulus);
    return (idx + 1 >= modulus) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/forward_lane_fifo.sv
// Per-lane result FIFO: stores ROB tag and value, exposes the head combinationally.
// Full is taken from the registered count only, so a full FIFO never accepts a push
// even when it is popped in the same cycle.
module forward_lane_fifo
  import forward_bus_arbiter_pkg::*;
#(
  parameter int unsigned XLEN            = CoreXlen,
  parameter int unsigned ROB_INDEX_WIDTH = CoreRobIndexWidth,
  parameter int unsigned DEPTH           = CoreLaneFifoDepth
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [ROB_INDEX_WIDTH-1:0] push_index_i,
  input  logic [XLEN-1:0]            push_value_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [ROB_INDEX_WIDTH-1:0] head_index_o,
  output logic [XLEN-1:0]            head_value_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ROB_INDEX_WIDTH-1:0] index_mem_q [DEPTH];
  logic [XLEN-1:0]            value_mem_q [DEPTH];
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic                       do_push, do_pop;

  assign full_o       = (count_q == CntW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign do_push      = push_i & ~full_o;
  assign do_pop       = pop_i & ~empty_o;
  assign head_index_o = index_mem_q[rd_ptr_q];
  assign head_value_o = value_mem_q[rd_ptr_q];

  // Pointer and occupancy update; flush discards this cycle's push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are only observed while the count says valid.
  always_ff @(posedge clock_i) begin
    if (do_push && !flush_i) begin
      index_mem_q[wr_ptr_q] <= push_index_i;
      value_mem_q[wr_ptr_q] <= push_value_i;
    end
  end

endmodule

// File: rtl/forward_bus_arbiter.sv
// Collects execution lane results into per-lane FIFOs and drives up to FORWARD_BUSSES of
// them per cycle onto registered forwarding busses, rotating priority from rr_ptr.
module forward_bus_arbiter
  import forward_bus_arbiter_pkg::*;
#(
  parameter int unsigned XLEN            = CoreXlen,
  parameter int unsigned ROB_INDEX_WIDTH = CoreRobIndexWidth,
  parameter int unsigned NUM_LANES       = CoreNumLanes,
  parameter int unsigned FORWARD_BUSSES  = CoreForwardBusses,
  parameter int unsigned LANE_FIFO_DEPTH = CoreLaneFifoDepth
) (
  input  logic                                      clock_i,
  input  logic                                      reset_i,
  input  logic                                      flush_i,
  input  logic [NUM_LANES-1:0]                      result_valids_i,
  output logic [NUM_LANES-1:0]                      result_readys_o,
  input  logic [NUM_LANES*ROB_INDEX_WIDTH-1:0]      result_indexes_i,
  input  logic [NUM_LANES*XLEN-1:0]                 result_values_i,
  output logic [FORWARD_BUSSES-1:0]                 forward_valids_o,
  output logic [FORWARD_BUSSES*ROB_INDEX_WIDTH-1:0] forward_indexes_o,
  output logic [FORWARD_BUSSES*XLEN-1:0]            forward_values_o
);

  localparam int unsigned LaneW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0]       lane_full, lane_empty, lane_push, lane_pop;
  logic [ROB_INDEX_WIDTH-1:0] lane_head_index [NUM_LANES];
  logic [XLEN-1:0]            lane_head_value [NUM_LANES];

  logic [NUM_LANES-1:0]       granted;
  logic [FORWARD_BUSSES-1:0]  grant_valid;
  logic [LaneW-1:0]           grant_lane [FORWARD_BUSSES];
  logic [LaneW-1:0]           last_lane;
  logic [LaneW-1:0]           rr_ptr_q, rr_ptr_d;

  logic [FORWARD_BUSSES-1:0]                 fwd_valid_q, fwd_valid_d;
  logic [FORWARD_BUSSES*ROB_INDEX_WIDTH-1:0] fwd_index_q, fwd_index_d;
  logic [FORWARD_BUSSES*XLEN-1:0]            fwd_value_q, fwd_value_d;

  assign result_readys_o = ~lane_full;
  assign lane_push       = result_valids_i & ~lane_full;
  assign lane_pop        = granted;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    forward_lane_fifo #(
      .XLEN            (XLEN),
      .ROB_INDEX_WIDTH (ROB_INDEX_WIDTH),
      .DEPTH           (LANE_FIFO_DEPTH)
    ) u_fifo (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .flush_i      (flush_i),
      .push_i       (lane_push[k]),
      .push_index_i (result_indexes_i[k*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH]),
      .push_value_i (result_values_i[k*XLEN +: XLEN]),
      .pop_i        (lane_pop[k]),
      .full_o       (lane_full[k]),
      .empty_o      (lane_empty[k]),
      .head_index_o (lane_head_index[k]),
      .head_value_o (lane_head_value[k])
    );
  end

  // Rotating priority selector: one pass per bus, masking lanes already granted so the
  // i-th grant in scan order lands on bus i.
  always_comb begin : p_arbiter
    int unsigned scan_idx;
    logic        found;
    scan_idx    = 0;
    found       = 1'b0;
    granted     = '0;
    grant_valid = '0;
    last_lane   = rr_ptr_q;
    for (int b = 0; b < FORWARD_BUSSES; b++) begin
      grant_lane[b] = '0;
      found         = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        scan_idx = (32'(rr_ptr_q) + 32'(i)) % NUM_LANES;
        if (!found && !lane_empty[scan_idx] && !granted[scan_idx]) begin
          found             = 1'b1;
          granted[scan_idx] = 1'b1;
          grant_valid[b]    = 1'b1;
          grant_lane[b]     = LaneW'(scan_idx);
          last_lane         = LaneW'(scan_idx);
        end
      end
    end
  end

  // Priority pointer moves past the last granted lane; flush restarts it at lane 0.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush_i) begin
      rr_ptr_d = '0;
    end else if (|grant_valid) begin
      rr_ptr_d = LaneW'(wrap_inc(32'(last_lane), NUM_LANES));
    end
  end

  // Bus payload selection; ungranted busses and flush cycles load zeros.
  always_comb begin
    fwd_valid_d = '0;
    fwd_index_d = '0;
    fwd_value_d = '0;
    if (!flush_i) begin
      for (int b = 0; b < FORWARD_BUSSES; b++) begin
        if (grant_valid[b]) begin
          fwd_valid_d[b]                                     = 1'b1;
          fwd_index_d[b*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH] = lane_head_index[grant_lane[b]];
          fwd_value_d[b*XLEN +: XLEN]                        = lane_head_value[grant_lane[b]];
        end
      end
    end
  end

  // Pointer and output bus registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rr_ptr_q    <= '0;
      fwd_valid_q <= '0;
      fwd_index_q <= '0;
      fwd_value_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_index_q <= fwd_index_d;
      fwd_value_q <= fwd_value_d;
    end
  end

  assign forward_valids_o  = fwd_valid_q;
  assign forward_indexes_o = fwd_index_q;
  assign forward_values_o  = fwd_value_q;

endmodule

// File: tb/tb_forward_bus_arbiter.sv
// Self-checking bench for forward_bus_arbiter: each scenario queues the bus beats it
// expects and compares them as the DUT produces them, cycle by cycle.
module tb_forward_bus_arbiter;

  localparam int XLEN = 64;
  localparam int RIW  = 8;
  localparam int NL   = 4;
  localparam int FB   = 2;
  localparam int FW   = FB + FB * RIW + FB * XLEN;

  logic                clock = 1'b0;
  logic                reset_i = 1'b0;
  logic                flush_i = 1'b0;
  logic [NL-1:0]       result_valids_i = '0;
  logic [NL-1:0]       result_readys_o;
  logic [NL*RIW-1:0]   result_indexes_i = '0;
  logic [NL*XLEN-1:0]  result_values_i = '0;
  logic [FB-1:0]       forward_valids_o;
  logic [FB*RIW-1:0]   forward_indexes_o;
  logic [FB*XLEN-1:0]  forward_values_o;
  logic [FW-1:0]       observed;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [FW-1:0] exp_q[$];

  assign observed = {forward_valids_o, forward_indexes_o, forward_values_o};

  forward_bus_arbiter dut (
    .clock_i           (clock),
    .reset_i           (reset_i),
    .flush_i           (flush_i),
    .result_valids_i   (result_valids_i),
    .result_readys_o   (result_readys_o),
    .result_indexes_i  (result_indexes_i),
    .result_values_i   (result_values_i),
    .forward_valids_o  (forward_valids_o),
    .forward_indexes_o (forward_indexes_o),
    .forward_values_o  (forward_values_o)
  );

  always #5 clock = ~clock;

  // Value carried with a tag: the tag repeated in every byte.
  function automatic logic [63:0] vof(input logic [7:0] t);
    return {8{t}};
  endfunction

  // Expected bus contents: valids, tags {bus1,bus0}, values {bus1,bus0}.
  function automatic logic [FW-1:0] beat(input logic [1:0] v, input logic [7:0] t0,
                                         input logic [7:0] t1);
    return {v, t1, t0, vof(t1), vof(t0)};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    result_valids_i  = '0;
    result_indexes_i = '0;
    result_values_i  = '0;
    flush_i          = 1'b0;
  endtask

  // Drive a lane mask with per-lane tags packed {t3,t2,t1,t0}.
  task automatic drive_vector(input logic [3:0] vm, input logic [31:0] tags);
    clear_inputs();
    for (int k = 0; k < NL; k++) begin
      if (vm[k]) begin
        result_valids_i[k]             = 1'b1;
        result_indexes_i[k*RIW +: RIW] = tags[k*8 +: 8];
        result_values_i[k*XLEN +: XLEN] = vof(tags[k*8 +: 8]);
      end
    end
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_i = 1'b0;
    step();
    step();
    reset_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    #2;
    tests_run++;
    if (observed !== '0) begin
      tests_failed++;
      $display("FAIL reset_busses: got %h want 0", observed);
    end
    tests_run++;
    if (result_readys_o !== 4'b1111) begin
      tests_failed++;
      $display("FAIL reset_readys: got %b want 1111", result_readys_o);
    end
    step();
    step();
    reset_i = 1'b1;
    for (int c = 0; c < 5; c++) exp_q.push_back('0);
    while (exp_q.size() != 0) begin
      logic [FW-1:0] e;
      step();
      e = exp_q.pop_front();
      tests_run++;
      if (observed !== e || result_readys_o !== 4'b1111) begin
        tests_failed++;
        $display("FAIL reset_idle: got %h rdy %b want %h rdy 1111", observed, result_readys_o, e);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    drive_vector(4'b0100, 32'h0007_0000);
    exp_q.push_back('0);
    exp_q.push_back(beat(2'b01, 8'd7, 8'd0));
    exp_q.push_back('0);
    while (exp_q.size() != 0) begin
      logic [FW-1:0] e;
      step();
      clear_inputs();
      e = exp_q.pop_front();
      tests_run++;
      if (observed !== e) begin
        tests_failed++;
        $display("FAIL single: got %h want %h", observed, e);
      end
    end
  endtask

  // All lanes at once, then a lane0+lane3 pair whose bus order reveals rr_ptr==0.
  task automatic test_contention();
    logic [3:0]  vm [6] = '{4'b1111, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
    logic [31:0] tg [6] = '{32'h04030201, 32'h0, 32'h0, 32'h06000005, 32'h0, 32'h0};
    apply_reset();
    exp_q.push_back('0);
    exp_q.push_back(beat(2'b11, 8'd1, 8'd2));
    exp_q.push_back(beat(2'b11, 8'd3, 8'd4));
    exp_q.push_back('0);
    exp_q.push_back(beat(2'b11, 8'd5, 8'd6));
    exp_q.push_back('0);
    for (int c = 0; c < 6; c++) begin
      logic [FW-1:0] e;
      drive_vector(vm[c], tg[c]);
      step();
      e = exp_q.pop_front();
      tests_run++;
      if (observed !== e) begin
        tests_failed++;
        $display("FAIL contention[%0d]: got %h want %h", c, observed, e);
      end
    end
    clear_inputs();
  endtask

  task automatic test_fairness();
    int low_run = 0;
    int max_low = 0;
    apply_reset();
    exp_q.push_back('0);
    for (int c = 0; c < 8; c++) exp_q.push_back(beat(2'b11, 8'h10 + 8'(c), 8'h30 + 8'(c)));
    exp_q.push_back('0);
    for (int c = 0; c < 10; c++) begin
      logic [FW-1:0] e;
      if (c < 8) drive_vector(4'b1001, {8'h30 + 8'(c), 16'h0, 8'h10 + 8'(c)});
      else clear_inputs();
      if (result_readys_o[0] !== 1'b1 || result_readys_o[3] !== 1'b1) low_run++;
      else low_run = 0;
      if (low_run > max_low) max_low = low_run;
      step();
      e = exp_q.pop_front();
      tests_run++;
      if (observed !== e) begin
        tests_failed++;
        $display("FAIL fairness[%0d]: got %h want %h", c, observed, e);
      end
    end
    clear_inputs();
    tests_run++;
    if (max_low > 2) begin
      tests_failed++;
      $display("FAIL fairness_ready_run: got %0d want <= 2", max_low);
    end
  endtask

  // Lane1 fills to two entries; a third push while full is refused, even though a pop
  // happens on that same edge.
  task automatic test_backpressure();
    logic [3:0]  vm  [6] = '{4'b1101, 4'b0111, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic [31:0] tg  [6] = '{32'h70600040, 32'h00615041, 32'h00005100, 32'h00005200,
                             32'h0, 32'h0};
    logic [3:0]  rdy [6] = '{4'b1111, 4'b1111, 4'b1101, 4'b1111, 4'b1111, 4'b1111};
    apply_reset();
    exp_q.push_back('0);
    exp_q.push_back(beat(2'b11, 8'h40, 8'h60));
    exp_q.push_back(beat(2'b11, 8'h70, 8'h41));
    exp_q.push_back(beat(2'b11, 8'h50, 8'h61));
    exp_q.push_back(beat(2'b01, 8'h51, 8'h00));
    exp_q.push_back('0);
    for (int c = 0; c < 6; c++) begin
      logic [FW-1:0] e;
      drive_vector(vm[c], tg[c]);
      step();
      e = exp_q.pop_front();
      tests_run++;
      if (observed !== e || result_readys_o !== rdy[c]) begin
        tests_failed++;
        $display("FAIL backpressure[%0d]: got %h rdy %b want %h rdy %b", c, observed,
                 result_readys_o, e, rdy[c]);
      end
    end
    clear_inputs();
  endtask

  // Five results buffered, flush with a simultaneous push; nothing stale may appear.
  task automatic test_flush();
    logic [3:0]  vm  [9] = '{4'b1111, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
                             4'b1001, 4'b0000, 4'b0000};
    logic [31:0] tg  [9] = '{32'h84838281, 32'h87868500, 32'h0000009F, 32'h0, 32'h0, 32'h0,
                             32'hA30000A1, 32'h0, 32'h0};
    logic [3:0]  rdy [9] = '{4'b1111, 4'b0011, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                             4'b1111, 4'b1111, 4'b1111};
    apply_reset();
    exp_q.push_back('0);
    exp_q.push_back(beat(2'b11, 8'h81, 8'h82));
    for (int c = 0; c < 5; c++) exp_q.push_back('0);
    exp_q.push_back(beat(2'b11, 8'hA1, 8'hA3));
    exp_q.push_back('0);
    for (int c = 0; c < 9; c++) begin
      logic [FW-1:0] e;
      drive_vector(vm[c], tg[c]);
      flush_i = (c == 2);
      step();
      e = exp_q.pop_front();
      tests_run++;
      if (observed !== e || result_readys_o !== rdy[c]) begin
        tests_failed++;
        $display("FAIL flush[%0d]: got %h rdy %b want %h rdy %b", c, observed,
                 result_readys_o, e, rdy[c]);
      end
    end
    clear_inputs();
  endtask

  // Reset dropped between edges must clear busses at once and lose buffered results.
  task automatic test_mid_reset();
    apply_reset();
    drive_vector(4'b1111, 32'hC4C3C2C1);
    step();
    clear_inputs();
    step();
    tests_run++;
    if (observed !== beat(2'b11, 8'hC1, 8'hC2)) begin
      tests_failed++;
      $display("FAIL mid_reset_pre: got %h want %h", observed, beat(2'b11, 8'hC1, 8'hC2));
    end
    #2;
    reset_i = 1'b0;
    #1;
    tests_run++;
    if (observed !== '0 || result_readys_o !== 4'b1111) begin
      tests_failed++;
      $display("FAIL mid_reset_async: got %h rdy %b want 0 rdy 1111", observed,
               result_readys_o);
    end
    step();
    reset_i = 1'b1;
    for (int c = 0; c < 3; c++) exp_q.push_back('0);
    while (exp_q.size() != 0) begin
      logic [FW-1:0] e;
      step();
      e = exp_q.pop_front();
      tests_run++;
      if (observed !== e) begin
        tests_failed++;
        $display("FAIL mid_reset_lost: got %h want %h", observed, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_flush();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
